imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and frame marker for the IMEM loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - UART byte-stream frame loader that writes words into IMEM
module imem_loader
    import loader_pkg::*;
#(
    parameter int         DWIDTH    = 32,
    parameter int         AWIDTH    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [DWIDTH-1:0] imem_din,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int          CNT_W = AWIDTH + 1;
    localparam logic [16:0] MAX_N = 17'(1) << AWIDTH;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       n_words;
    logic [15:0]       n_next;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  idx_next;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic [DWIDTH-1:0] word_buf;
    logic [DWIDTH-1:0] word_next;
    logic              accept;

    assign accept   = rx_valid && rx_ready;
    assign n_next   = {rx_data, len_lo};
    assign idx_next = word_idx + CNT_W'(1);

    // Word as it will look once the current byte lands in its little-endian lane.
    always_comb begin
        word_next = word_buf;
        word_next[{byte_cnt, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_lo    <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            word_buf  <= '0;
            rx_ready  <= 1'b1;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_din  <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state    <= LEN0;
                        cpu_hold <= 1'b1;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        n_words  <= n_next;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        if (n_next == 16'd0 || {1'b0, n_next} > MAX_N) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_buf <= word_next;
                        csum     <= csum + rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Outputs are registered, so the write strobe is set up here for the WRITE cycle.
                        if (byte_cnt == 2'd3) begin
                            state     <= WRITE;
                            rx_ready  <= 1'b0;
                            imem_we   <= 1'b1;
                            imem_addr <= word_idx[AWIDTH-1:0];
                            imem_din  <= word_next;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= idx_next;
                    rx_ready <= 1'b1;
                    state    <= (17'(idx_next) < 17'(n_words)) ? DATA : CSUM;
                end
                CSUM: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    rx_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    rx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed frame vectors and corner sequences for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_din;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_din  (imem_din),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:15][7:0] b;
        int               nbytes;
        int               nwr;
        logic [31:0]      din [3];
        bit               done;
        bit               err;
        bit               rnd;
    } vec_t;

    vec_t vecs [7];

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0]  wr_addr [$];
    logic [31:0] wr_din  [$];
    logic        wr_rdy  [$];
    logic        wr_lat  [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic        prev_acc = 1'b0;

    // Write events are logged together with whether a byte was accepted the cycle before.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_din.push_back(imem_din);
                wr_rdy.push_back(rx_ready);
                wr_lat.push_back(prev_acc);
            end
            if (load_done) done_cnt++;
            if (load_err)  err_cnt++;
        end
        prev_acc = rx_valid && rx_ready && !rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        logic acc;
        int   t;
        if (rnd) idle($urandom_range(0, 3));
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("rx_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int w0, d0, e0;
        w0 = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].b[j], vecs[i].rnd);
        idle(5);
        check($sformatf("v%0d_nwr", i), 32'(wr_addr.size() - w0), 32'(vecs[i].nwr));
        for (int k = 0; k < vecs[i].nwr && w0 + k < wr_addr.size(); k++) begin
            check($sformatf("v%0d_addr%0d", i, k), 32'(wr_addr[w0+k]), 32'(k));
            check($sformatf("v%0d_din%0d", i, k), wr_din[w0+k], vecs[i].din[k]);
            check($sformatf("v%0d_rdy_in_write%0d", i, k), 32'(wr_rdy[w0+k]), 32'd0);
            check($sformatf("v%0d_latency%0d", i, k), 32'(wr_lat[w0+k]), 32'd1);
        end
        check($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].done));
        check($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].err));
        check($sformatf("v%0d_hold_after", i), 32'(cpu_hold), 32'd0);
        check($sformatf("v%0d_ready_after", i), 32'(rx_ready), 32'd1);
    endtask

    initial begin
        int          w0, d0, e0, bad;
        logic [31:0] w;
        logic [7:0]  cs;

        for (int i = 0; i < 7; i++) begin
            vecs[i].b      = '0;
            vecs[i].nbytes = 0;
            vecs[i].nwr    = 0;
            vecs[i].din    = '{32'h0, 32'h0, 32'h0};
            vecs[i].done   = 1'b0;
            vecs[i].err    = 1'b0;
            vecs[i].rnd    = 1'b0;
        end
        vecs[0].b = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 64'h0};
        vecs[0].nbytes = 8;  vecs[0].nwr = 1; vecs[0].din[0] = 32'h0000_0013; vecs[0].done = 1'b1;
        vecs[1].b = {8'hA5, 8'h02, 8'h00, 32'h44332211, 32'hDDCCBBAA, 8'hB8, 32'h0};
        vecs[1].nbytes = 12; vecs[1].nwr = 2; vecs[1].done = 1'b1;
        vecs[1].din[0] = 32'h1122_3344; vecs[1].din[1] = 32'hAABB_CCDD;
        vecs[2].b = {8'hA5, 8'h02, 8'h00, 32'h44332211, 32'hDDCCBBAA, 8'hB9, 32'h0};
        vecs[2].nbytes = 12; vecs[2].nwr = 2; vecs[2].err = 1'b1;
        vecs[2].din[0] = 32'h1122_3344; vecs[2].din[1] = 32'hAABB_CCDD;
        vecs[3].b = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 88'h0};
        vecs[3].nbytes = 5;  vecs[3].err = 1'b1;
        vecs[4].b = {8'hA5, 8'h01, 8'h04, 104'h0};
        vecs[4].nbytes = 3;  vecs[4].err = 1'b1;
        vecs[5].b = {8'hA5, 8'h03, 8'h00, 32'h04030201, 32'hEFBEADDE, 32'h80000000, 8'hC2};
        vecs[5].nbytes = 16; vecs[5].nwr = 3; vecs[5].done = 1'b1; vecs[5].rnd = 1'b1;
        vecs[5].din[0] = 32'h0102_0304; vecs[5].din[1] = 32'hDEAD_BEEF; vecs[5].din[2] = 32'h0000_0080;
        vecs[6] = vecs[5];
        vecs[6].rnd = 1'b0;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rx_ready", 32'(rx_ready), 32'd1);
        check("reset_imem_we", 32'(imem_we), 32'd0);
        check("reset_cpu_hold", 32'(cpu_hold), 32'd0);
        check("reset_load_done", 32'(load_done), 32'd0);
        check("reset_load_err", 32'(load_err), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Largest legal frame: 1024 words must end at the top address with no wrap.
        w0 = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        check("n1024_hold_mid", 32'(cpu_hold), 32'd1);
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w = 32'h5A00_0000 | 32'(i);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 1'b0);
                cs = cs + w[8*k +: 8];
            end
        end
        send_byte(cs, 1'b0);
        idle(5);
        check("n1024_nwr", 32'(wr_addr.size() - w0), 32'd1024);
        bad = 0;
        for (int i = 0; i < 1024 && w0 + i < wr_addr.size(); i++) begin
            if (wr_addr[w0+i] !== 10'(i) || wr_din[w0+i] !== (32'h5A00_0000 | 32'(i))) bad++;
        end
        check("n1024_bad_words", 32'(bad), 32'd0);
        if (wr_addr.size() > 0) check("n1024_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'h3FF);
        check("n1024_done", 32'(done_cnt - d0), 32'd1);
        check("n1024_err", 32'(err_cnt - e0), 32'd0);

        // Reset in the middle of the second word abandons the frame silently.
        w0 = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd1);
        check("midrst_imem_we", 32'(imem_we), 32'd0);
        rst = 1'b0;
        idle(4);
        check("midrst_nwr", 32'(wr_addr.size() - w0), 32'd1);
        if (wr_din.size() > w0) check("midrst_din0", wr_din[w0], 32'h1234_5678);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
